fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-style floating-point adder computing z = a + b for any (E,M) format
//  (bf16 by default). Full sign handling (add/sub), special values, optional round-to-nearest-even.
//  Registered valid/ready stream; sits between operand issue and result writeback in the FP datapath.
// PARAMETERS
//  E       8   exponent width (bias = 2**(E-1)-1)
//  M       7   stored mantissa width (hidden 1 not stored)
// PORTS
//  clk      in   1  clock, all state on rising edge
//  rst      in   1  synchronous reset, active-high
//  valid_i  in   1  operand pair valid
//  ready_o  out  1  adder can accept operands this cycle
//  sa_i     in   1  sign a
//  ea_i     in   E  exponent a
//  ma_i     in   M  mantissa a
//  sb_i     in   1  sign b
//  eb_i     in   E  exponent b
//  mb_i     in   M  mantissa b
//  valid_o  out  1  result valid
//  ready_i  in   1  consumer accepts result
//  s_o      out  1  result sign
//  e_o      out  E  result exponent
//  m_o      out  M  result mantissa
//  flags_o  out  3  {invalid, overflow, underflow}, qualified by valid_o
// BEHAVIOUR
//  - Clock clk, reset rst: one clock; reset is synchronous and active-high.
//  - Reset: valid_o=0, s_o=0, e_o=0, m_o=0, flags_o=0; all stage valids cleared. Reset mid-operation drops in-flight ops.
//  - 3 register stages, latency 3 cycles, throughput 1/cycle. Global stall: en = ~v3 | ready_i; ready_o = en.
//    Input accepted on valid_i & ready_o. While valid_o & ~ready_i all stages hold; output fields stay stable.
//  - S1: unpack, classify (zero/sub/inf/nan), swap so |x|>=|y| (exp, then mantissa on tie), d = ex-ey.
//  - S2: align my right by d, d>=M+4 -> my contributes sticky only; add/sub on M+4 bits (hidden,M,G,R,S);
//    LZC of result (lzc instance).
//  - S3: normalise (carry -> >>1, exp+1; cancellation -> <<lzc, exp-lzc), round, pack, special override.
//  - Sign: s_x (sign of larger magnitude). Exact cancellation -> +0. (-0)+(-0) -> -0.
//  - Subnormal inputs treated as zero (DAZ); result exponent <=0 -> signed zero, underflow=1 (FTZ).
//  - Result exponent >= 2**E-1 after rounding -> signed inf (e=all1, m=0), overflow=1.
//  - NaN input, or inf + (-inf) -> canonical qNaN {0, all1, 1<<(M-1)}; invalid=1 for inf-inf only.
//  - inf + finite -> that inf, no flags. Flags from at most one source per result.
// CONFIGURATION
//  FP_ADD_RNE_EN defined: round-to-nearest, ties-to-even from G/R/S; mantissa round carry renormalises, exp+1.
//  FP_ADD_RNE_EN undefined: round-toward-zero; G/R/S discarded (S2 adder may shrink to M+2 bits); overflow
//  saturates to max finite (e=all1-1, m=all1) instead of inf, overflow flag still set.
// STRUCTURE
//  fp_pkg: fp_class_t enum (ZERO,NORM,INF,NAN), typedef'd stage payload structs, BIAS/QNAN constants as functions of E,M.
//  Sub-module: lzc (existing, W = pow2 >= M+4) for cancellation count. Rest inline in fp_add_pipe.
// TESTING (bf16, {s,e,m} hex)
//  1: 0x3F80 + 0x3F80 -> 0x4000 after exactly 3 cycles, flags 0.
//  2: 0x3F80 + 0xBF80 -> 0x0000 (+0); 0x8000 + 0x8000 -> 0x8000.
//  3: 0x3F81 + 0x3B80 (tie) -> RNE 0x3F82; RTZ 0x3F81.
//  4: 0x7F7F + 0x7F7F -> RNE 0x7F80 overflow=1; RTZ 0x7F7F overflow=1. 0x7F80 + 0xFF80 -> 0x7FC0 invalid=1.
//  5: 0x0080 + 0x8001 (subnormal b as 0) -> 0x0080; 0x0081 - 0x0080 -> 0x0000 underflow=1.
//  6: back-to-back stream of 16 ops, ready_i toggled random, rst pulsed mid-stream -> no drop/dup, order kept,
//     outputs stable under stall, valid_o=0 cycle after reset.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the pipelined adder.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    localparam int FLG_INV = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UDF = 0;

    function automatic int fp_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

    // Subnormals fold into ZERO: the adder flushes them on input.
    function automatic fp_class_t fp_classify(input logic e_zero, input logic e_ones,
                                              input logic m_zero);
        if (e_zero)
            return FP_ZERO;
        else if (e_ones)
            return m_zero ? FP_INF : FP_NAN;
        else
            return FP_NORM;
    endfunction

    function automatic int fp_lzc_width(input int w);
        int p;
        p = 1;
        for (int i = 0; i < 32; i++)
            if (p < w) p = p * 2;
        return p;
    endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter over a power-of-two wide vector; all-zero input returns W.
// Latency: combinational.
// Backpressure: not applicable.
module lzc #(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  in_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++)
            if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined (E,M) floating-point adder z = a + b, DAZ/FTZ; FP_ADD_RNE_EN selects RNE, else RTZ.
// Latency: 3 cycles, throughput 1/cycle.
// Backpressure: global stall, all stages hold while valid_o & ~ready_i; ready_o = ~valid_o | ready_i.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         sa_i,
    input  logic [E-1:0] ea_i,
    input  logic [M-1:0] ma_i,
    input  logic         sb_i,
    input  logic [E-1:0] eb_i,
    input  logic [M-1:0] mb_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         s_o,
    output logic [E-1:0] e_o,
    output logic [M-1:0] m_o,
    output logic [2:0]   flags_o
);

    localparam int W   = M + 4;
    localparam int LW  = fp_lzc_width(W);
    localparam int LCW = $clog2(LW) + 1;
    localparam int XW  = E + 2;
    localparam logic [E-1:0]          EONES = '1;
    localparam logic [E-1:0]          DMAX  = E'(W);
    localparam logic signed [XW-1:0]  XMAX  = XW'((1 << E) - 1);
    localparam logic [E+M:0]          QNAN  = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef struct packed {
        logic         vld;
        logic         sx;
        logic         sub;
        logic [E-1:0] ex;
        logic [E-1:0] d;
        logic [M:0]   mx;
        logic [M:0]   my;
        logic         spec;
        logic [E+M:0] spec_val;
        logic [2:0]   spec_flg;
    } s1_t;

    typedef struct packed {
        logic           vld;
        logic           sx;
        logic [E-1:0]   ex;
        logic [W:0]     sum;
        logic [LCW-1:0] lz;
        logic           spec;
        logic [E+M:0]   spec_val;
        logic [2:0]     spec_flg;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic         vo_q, so_q, so_d;
    logic [E-1:0] eo_q, eo_d;
    logic [M-1:0] mo_q, mo_d;
    logic [2:0]   fo_q, fo_d;
    logic         en;

    assign en      = ~vo_q | ready_i;
    assign ready_o = en;
    assign valid_o = vo_q;
    assign s_o     = so_q;
    assign e_o     = eo_q;
    assign m_o     = mo_q;
    assign flags_o = fo_q;

    // Stage 1: classify, order by magnitude, exponent difference, special results.
    fp_class_t      ca, cb;
    logic [E+M-1:0] mag_a, mag_b;
    logic [M:0]     fa, fb;
    logic           a_big, inf_inf;

    always_comb begin
        ca      = fp_classify(ea_i == '0, ea_i == EONES, ma_i == '0);
        cb      = fp_classify(eb_i == '0, eb_i == EONES, mb_i == '0);
        mag_a   = (ca == FP_NORM) ? {ea_i, ma_i} : '0;
        mag_b   = (cb == FP_NORM) ? {eb_i, mb_i} : '0;
        fa      = {ca == FP_NORM, mag_a[M-1:0]};
        fb      = {cb == FP_NORM, mag_b[M-1:0]};
        a_big   = mag_a >= mag_b;
        inf_inf = (ca == FP_INF) && (cb == FP_INF) && (sa_i != sb_i);
        s1_d     = '0;
        s1_d.vld = valid_i;
        s1_d.sub = sa_i ^ sb_i;
        if (a_big) begin
            s1_d.sx = sa_i;
            s1_d.ex = mag_a[E+M-1:M];
            s1_d.d  = mag_a[E+M-1:M] - mag_b[E+M-1:M];
            s1_d.mx = fa;
            s1_d.my = fb;
        end else begin
            s1_d.sx = sb_i;
            s1_d.ex = mag_b[E+M-1:M];
            s1_d.d  = mag_b[E+M-1:M] - mag_a[E+M-1:M];
            s1_d.mx = fb;
            s1_d.my = fa;
        end
        if (ca == FP_NAN || cb == FP_NAN || inf_inf) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = QNAN;
            s1_d.spec_flg = {inf_inf, 2'b00};
        end else if (ca == FP_INF) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = {sa_i, EONES, {M{1'b0}}};
        end else if (cb == FP_INF) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = {sb_i, EONES, {M{1'b0}}};
        end else if (ca == FP_ZERO && cb == FP_ZERO) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_val = {sa_i & sb_i, {(E+M){1'b0}}};
        end
    end

    // Stage 2: align the smaller operand with sticky jam, add/sub, count leading zeros.
    logic [2*W-1:0] sh;
    logic [W-1:0]   mx_e, al;
    logic [LW-1:0]  lz_in;
    logic [LCW-1:0] lz_cnt;

    always_comb begin
        mx_e = {s1_q.mx, 3'b000};
        sh   = {s1_q.my, 3'b000, {W{1'b0}}} >> s1_q.d;
        if (s1_q.d >= DMAX) begin
            al = {{(W-1){1'b0}}, |s1_q.my};
        end else begin
            al    = sh[2*W-1:W];
            al[0] = al[0] | (|sh[W-1:0]);
        end
        s2_d          = '0;
        s2_d.vld      = s1_q.vld;
        s2_d.sx       = s1_q.sx;
        s2_d.ex       = s1_q.ex;
        s2_d.sum      = s1_q.sub ? ({1'b0, mx_e} - {1'b0, al}) : ({1'b0, mx_e} + {1'b0, al});
        s2_d.lz       = lz_cnt;
        s2_d.spec     = s1_q.spec;
        s2_d.spec_val = s1_q.spec_val;
        s2_d.spec_flg = s1_q.spec_flg;
        lz_in         = LW'(s2_d.sum[W-1:0]) << (LW - W);
    end

    lzc #(.W(LW), .CW(LCW)) u_lzc (
        .in_i  (lz_in),
        .cnt_o (lz_cnt)
    );

    // Stage 3: normalise, round, detect range limits, apply special overrides.
    logic [W-1:0]           n;
    logic signed [XW-1:0]   xe, xr;
    logic [M+1:0]           mant_r;
    logic [M-1:0]           mfin;
    logic                   inc;

    always_comb begin
        if (s2_q.sum[W]) begin
            n    = s2_q.sum[W:1];
            n[0] = n[0] | s2_q.sum[0];
            xe   = XW'(s2_q.ex) + XW'(1);
        end else begin
            n  = s2_q.sum[W-1:0] << s2_q.lz;
            xe = XW'(s2_q.ex) - XW'(s2_q.lz);
        end
`ifdef FP_ADD_RNE_EN
        inc = n[2] & (n[1] | n[0] | n[3]);
`else
        inc = 1'b0;
`endif
        mant_r = (M+2)'({1'b0, n} >> 3) + (M+2)'(inc);
        if (mant_r[M+1]) begin
            xr   = xe + XW'(1);
            mfin = mant_r[M:1];
        end else begin
            xr   = xe;
            mfin = mant_r[M-1:0];
        end
        so_d = s2_q.sx;
        eo_d = xr[E-1:0];
        mo_d = mfin;
        fo_d = 3'b000;
        if (s2_q.spec) begin
            {so_d, eo_d, mo_d} = s2_q.spec_val;
            fo_d               = s2_q.spec_flg;
        end else if (s2_q.sum == '0) begin
            {so_d, eo_d, mo_d} = '0;
        end else if (xe <= 0) begin
            eo_d          = '0;
            mo_d          = '0;
            fo_d[FLG_UDF] = 1'b1;
        end else if (xr >= XMAX) begin
`ifdef FP_ADD_RNE_EN
            eo_d = EONES;
            mo_d = '0;
`else
            eo_d = EONES - E'(1);
            mo_d = '1;
`endif
            fo_d[FLG_OVF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.vld <= 1'b0;
            s2_q.vld <= 1'b0;
            vo_q     <= 1'b0;
            so_q     <= 1'b0;
            eo_q     <= '0;
            mo_q     <= '0;
            fo_q     <= '0;
        end else if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            vo_q <= s2_q.vld;
            so_q <= so_d;
            eo_q <= eo_d;
            mo_q <= mo_d;
            fo_q <= fo_d;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe (bf16): directed spec cases plus random stream with stalls and reset.
module tb_fp_add_pipe;

    logic       clk = 1'b0;
    logic       rst, valid_i, ready_o, ready_i, valid_o;
    logic       sa_i, sb_i, s_o;
    logic [7:0] ea_i, eb_i, e_o;
    logic [6:0] ma_i, mb_i, m_o;
    logic [2:0] flags_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rdy = 1'b0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i), .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
        .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .e_o(e_o), .m_o(m_o), .flags_o(flags_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Exact sum as a wide integer (units of the smallest normal ulp), then rounded to 8 significant bits.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [299:0] na, nb, n;
        logic [8:0]   sig;
        logic         s, za, zb, ia, ib, qa, qb, ii;
        int           p, ex;
`ifdef FP_ADD_RNE_EN
        logic [299:0] rem, half;
`endif
        za = a[14:7] == 8'h00;
        zb = b[14:7] == 8'h00;
        ia = a[14:7] == 8'hFF && a[6:0] == 7'h0;
        ib = b[14:7] == 8'hFF && b[6:0] == 7'h0;
        qa = a[14:7] == 8'hFF && a[6:0] != 7'h0;
        qb = b[14:7] == 8'hFF && b[6:0] != 7'h0;
        ii = ia && ib && (a[15] != b[15]);
        if (qa || qb || ii) return {16'h7FC0, ii, 2'b00};
        if (ia) return {a[15], 8'hFF, 7'h00, 3'b000};
        if (ib) return {b[15], 8'hFF, 7'h00, 3'b000};
        if (za && zb) return {a[15] & b[15], 15'h0, 3'b000};
        na = za ? '0 : (300'({1'b1, a[6:0]}) << (int'(a[14:7]) - 1));
        nb = zb ? '0 : (300'({1'b1, b[6:0]}) << (int'(b[14:7]) - 1));
        if (a[15] == b[15]) begin
            n = na + nb; s = a[15];
        end else if (na >= nb) begin
            n = na - nb; s = a[15];
        end else begin
            n = nb - na; s = b[15];
        end
        if (n == '0) return 19'h0;
        p = -1;
        for (int i = 0; i < 300; i++)
            if (n[i]) p = i;
        ex = p - 6;
        if (ex <= 0) return {s, 15'h0, 3'b001};
        sig = 9'(n >> (p - 7));
`ifdef FP_ADD_RNE_EN
        if (p > 7) begin
            rem  = n & ((300'(1) << (p - 7)) - 300'(1));
            half = 300'(1) << (p - 8);
            if (rem > half || (rem == half && sig[0])) sig = sig + 9'd1;
        end
        if (sig[8]) begin
            sig = sig >> 1;
            ex  = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 7'h00, 3'b010};
`else
        if (ex >= 255) return {s, 8'hFE, 7'h7F, 3'b010};
`endif
        return {s, 8'(ex), sig[6:0], 3'b000};
    endfunction

    function automatic logic [15:0] rand_fp();
        case ($urandom_range(0, 19))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7F80;
            3: return 16'hFF80;
            4: return 16'h7FC1;
            5: return 16'h0005;
            6: return 16'h7F7F;
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 7'($urandom)};
        endcase
    endfunction

    function automatic logic [15:0] rand_near(input logic [15:0] a);
        int e;
        e = int'(a[14:7]) + int'($urandom_range(0, 18)) - 9;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), 8'(e), 7'($urandom)};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [18:0] expv);
        bit acc;
        int cyc;
        {sa_i, ea_i, ma_i} = a;
        {sb_i, eb_i, mb_i} = b;
        valid_i = 1'b1;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            if (ready_o && !rst) begin
                exp_q.push_back(expv);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: operands %h %h not accepted, expected accept", a, b);
        end
    endtask

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops on every output transfer and checks stability across stalls.
    initial begin
        logic        stalled;
        logic [19:0] held, cur;
        logic [18:0] e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                cur = {valid_o, s_o, e_o, m_o, flags_o};
                if (stalled) check("stall_hold", 32'(cur), 32'(held));
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h, expected no output", cur[18:0]);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'(cur[18:0]), 32'(e));
                    end
                end
                stalled = valid_o && !ready_i;
                held    = cur;
            end
        end
    end

    logic [15:0] da [0:11] = '{16'h3F80, 16'h3F80, 16'h8000, 16'h3F81, 16'h7F7F, 16'h7F80,
                               16'h0080, 16'h0081, 16'h7FC1, 16'hFF80, 16'h0000, 16'hC000};
    logic [15:0] db [0:11] = '{16'h3F80, 16'hBF80, 16'h8000, 16'h3B80, 16'h7F7F, 16'hFF80,
                               16'h8001, 16'h8080, 16'h3F80, 16'h3F80, 16'h8000, 16'h3F80};
`ifdef FP_ADD_RNE_EN
    logic [18:0] de [0:11] = '{{16'h4000, 3'b000}, {16'h0000, 3'b000}, {16'h8000, 3'b000},
                               {16'h3F82, 3'b000}, {16'h7F80, 3'b010}, {16'h7FC0, 3'b100},
                               {16'h0080, 3'b000}, {16'h0000, 3'b001}, {16'h7FC0, 3'b000},
                               {16'hFF80, 3'b000}, {16'h0000, 3'b000}, {16'hBF80, 3'b000}};
`else
    logic [18:0] de [0:11] = '{{16'h4000, 3'b000}, {16'h0000, 3'b000}, {16'h8000, 3'b000},
                               {16'h3F81, 3'b000}, {16'h7F7F, 3'b010}, {16'h7FC0, 3'b100},
                               {16'h0080, 3'b000}, {16'h0000, 3'b001}, {16'h7FC0, 3'b000},
                               {16'hFF80, 3'b000}, {16'h0000, 3'b000}, {16'hBF80, 3'b000}};
`endif

    initial begin
        logic [15:0] a, b;
        int lat, cyc;
        rst = 1'b1;
        valid_i = 1'b0;
        {sa_i, ea_i, ma_i} = '0;
        {sb_i, eb_i, mb_i} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'({valid_o, s_o, e_o, m_o, flags_o}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First result must appear exactly three edges after acceptance.
        issue(da[0], db[0], de[0]);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 1; i < 12; i++) issue(da[i], db[i], de[i]);
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = rand_fp();
            b = ($urandom_range(0, 1) == 1) ? rand_near(a) : rand_fp();
            issue(a, b, model(a, b));
            if (i == 8) begin
                rst = 1'b1;
                valid_i = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_q.delete();
                check("post_reset_out", 32'({valid_o, s_o, e_o, m_o, flags_o}), 32'd0);
            end
        end
        for (int i = 0; i < 200; i++) begin
            a = rand_fp();
            b = ($urandom_range(0, 2) != 0) ? rand_near(a) : rand_fp();
            if ($urandom_range(0, 9) == 0) b = {~a[15], a[14:0]};
            issue(a, b, model(a, b));
        end
        valid_i = 1'b0;
        rand_rdy = 1'b0;

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
